// File: rtl/mindfocus_pkg.sv
// MindFocus shared definitions: state codes, default timing
// and small elaboration helpers used by control and datapath.
package mindfocus_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    MOSTRA   = 4'd2,
    ESPERA   = 4'd3,
    REGISTRA = 4'd4,
    COMPARA  = 4'd5,
    ACERTO   = 4'd6,
    PROXIMA  = 4'd7,
    FIM      = 4'd8
  } estado_t;

  localparam int T_SHOW_DEF = 5000;
  localparam int T_PLAY_DEF = 5000;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int larg(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mindfocus_controle_contador.sv
// Modulus-M phase timer: synchronous clear, enable,
// holds at M-1 instead of wrapping.
module contador_m
  import mindfocus_pkg::*;
#(
  parameter int M = 16,
  parameter int W = larg(M)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         fim
);

  assign fim = (q == W'(M - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && !fim) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mindfocus_controle.sv
// MindFocus control unit: sequences display, play window,
// comparison and scoring over ROUNDS rounds.
module mindfocus_controle
  import mindfocus_pkg::*;
#(
  parameter int ROUNDS = 4,
  parameter int T_SHOW = T_SHOW_DEF,
  parameter int T_PLAY = T_PLAY_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       voltar,
  input  logic [3:0] botoes,
  input  logic       igual,
  output logic       zera,
  output logic       mostra,
  output logic       registra,
  output logic       conta_acerto,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] indice,
  output logic [3:0] db_estado
);

  localparam int TMAX = max_i(T_SHOW, T_PLAY);
  localparam int TW   = larg(TMAX);

  localparam logic [TW-1:0] LIM_SHOW = TW'(T_SHOW - 1);
  localparam logic [TW-1:0] LIM_PLAY = TW'(T_PLAY - 1);
  localparam logic [3:0]    ULTIMA   = 4'(ROUNDS - 1);

  estado_t       estado;
  estado_t       prox;
  logic [TW-1:0] tempo;
  logic          tempo_fim;
  logic          t_clr;
  logic          t_en;
  logic          prev;
  logic          borda;
  logic          fim_show;
  logic          fim_play;

  assign borda    = (|botoes) & ~prev;
  assign fim_show = tempo_fim || (tempo == LIM_SHOW);
  assign fim_play = tempo_fim || (tempo == LIM_PLAY);

  // every state change restarts the timer for the next phase
  assign t_clr = (prox != estado);
  assign t_en  = (estado == MOSTRA) || (estado == ESPERA);

  contador_m #(
    .M (TMAX),
    .W (TW)
  ) u_tempo (
    .clock (clock),
    .reset (reset),
    .clr   (t_clr),
    .en    (t_en),
    .q     (tempo),
    .fim   (tempo_fim)
  );

  always_comb begin
    prox = estado;
    if (voltar && estado != INICIAL) begin
      prox = INICIAL;
    end else begin
      unique case (estado)
        INICIAL:  if (iniciar && !voltar) prox = PREPARA;
        PREPARA:  prox = MOSTRA;
        MOSTRA:   if (fim_show) prox = ESPERA;
        ESPERA: begin
          if (borda)         prox = REGISTRA;
          else if (fim_play) prox = PROXIMA;
        end
        REGISTRA: prox = COMPARA;
        COMPARA:  prox = igual ? ACERTO : PROXIMA;
        ACERTO:   prox = PROXIMA;
        PROXIMA:  prox = (indice == ULTIMA) ? FIM : MOSTRA;
        FIM:      prox = FIM;
        default:  prox = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      indice       <= 4'd0;
      prev         <= 1'b0;
      zera         <= 1'b0;
      mostra       <= 1'b0;
      registra     <= 1'b0;
      conta_acerto <= 1'b0;
      timeout      <= 1'b0;
      pronto       <= 1'b0;
      db_estado    <= 4'd0;
    end else begin
      estado <= prox;
      prev   <= |botoes;
      if (prox == PREPARA) begin
        indice <= 4'd0;
      end else if (estado == PROXIMA && prox == MOSTRA) begin
        indice <= indice + 4'd1;
      end
      zera         <= (prox == PREPARA);
      mostra       <= (prox == MOSTRA);
      registra     <= (prox == REGISTRA);
      conta_acerto <= (prox == ACERTO);
      timeout      <= (estado == ESPERA) && (prox == PROXIMA);
      pronto       <= (prox == FIM);
      db_estado    <= prox;
    end
  end

endmodule

// File: tb/tb_mindfocus_controle.sv
// Directed plus randomized checks of the MindFocus control
// unit against round-level timing expectations.
module tb_mindfocus_controle;

  localparam int ROUNDS = 4;
  localparam int T_SHOW = 6;
  localparam int T_PLAY = 9;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       voltar;
  logic [3:0] botoes;
  logic       igual;
  logic       zera;
  logic       mostra;
  logic       registra;
  logic       conta_acerto;
  logic       timeout;
  logic       pronto;
  logic [3:0] indice;
  logic [3:0] db_estado;

  int checks;
  int errors;
  int hits;
  int n_acerto;

  mindfocus_controle #(
    .ROUNDS (ROUNDS),
    .T_SHOW (T_SHOW),
    .T_PLAY (T_PLAY)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .voltar       (voltar),
    .botoes       (botoes),
    .igual        (igual),
    .zera         (zera),
    .mostra       (mostra),
    .registra     (registra),
    .conta_acerto (conta_acerto),
    .timeout      (timeout),
    .pronto       (pronto),
    .indice       (indice),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (conta_acerto === 1'b1) n_acerto++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic iniciar_jogo();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("zera", 32'(zera), 1);
    chk("prepara", 32'(db_estado), 1);
    chk("indice0", 32'(indice), 0);
    step();
    chk("zera_pulse", 32'(zera), 0);
    chk("mostra_start", 32'(mostra), 1);
  endtask

  // one round, entered on the first observed MOSTRA cycle;
  // d = ESPERA cycle whose closing edge samples the press
  task automatic rodada(input int r, input int d, input bit hit,
                        input bit held);
    int n;
    bit reg_ok;
    chk("indice", 32'(indice), 32'(r));
    botoes = held ? 4'b1000 : 4'b0000;
    n = 0;
    while (mostra === 1'b1 && n < T_SHOW + 4) begin
      n++;
      step();
    end
    chk("mostra_len", 32'(n), 32'(T_SHOW));
    chk("espera", 32'(db_estado), 3);
    reg_ok = 1'b0;
    for (int j = 0; j < T_PLAY; j++) begin
      if (!held && j == d) botoes = 4'b1000;
      step();
      if (!held && j == d) begin
        chk("registra", 32'(registra), 1);
        chk("tie_no_timeout", 32'(timeout), 0);
        reg_ok = 1'b1;
        break;
      end
      if (j == T_PLAY - 1) begin
        chk("timeout", 32'(timeout), 1);
        chk("no_registra", 32'(registra), 0);
      end else begin
        chk("espera_hold", 32'(db_estado), 3);
      end
    end
    botoes = 4'b0000;
    if (reg_ok) begin
      igual = hit;
      step();
      chk("compara", 32'(db_estado), 5);
      chk("reg_pulse", 32'(registra), 0);
      step();
      if (hit) begin
        chk("acerto", 32'(conta_acerto), 1);
        hits++;
        step();
        chk("acerto_pulse", 32'(conta_acerto), 0);
      end else begin
        chk("miss_no_acerto", 32'(conta_acerto), 0);
      end
    end
    chk("proxima", 32'(db_estado), 7);
    chk("proxima_indice", 32'(indice), 32'(r));
    step();
    chk("timeout_pulse", 32'(timeout), 0);
    if (r == ROUNDS - 1) begin
      chk("pronto", 32'(pronto), 1);
    end else begin
      chk("mostra_next", 32'(mostra), 1);
      chk("indice_inc", 32'(indice), 32'(r + 1));
    end
  endtask

  task automatic fim_jogo(input int exp_hits, input int base);
    step();
    chk("pronto_hold", 32'(pronto), 1);
    chk("fim", 32'(db_estado), 8);
    chk("n_acerto", 32'(n_acerto - base), 32'(exp_hits));
    voltar = 1'b1;
    step();
    voltar = 1'b0;
    chk("voltar_fim", 32'(db_estado), 0);
    chk("pronto_off", 32'(pronto), 0);
  endtask

  initial begin
    int base;
    int n;
    checks   = 0;
    errors   = 0;
    hits     = 0;
    n_acerto = 0;
    reset    = 1'b1;
    iniciar  = 1'b0;
    voltar   = 1'b0;
    botoes   = 4'b0000;
    igual    = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_outs", 32'({zera, mostra, registra, conta_acerto,
                         timeout, pronto}), 0);
    chk("rst_indice", 32'(indice), 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("post_rst", 32'(db_estado), 0);

    iniciar = 1'b1;
    voltar  = 1'b1;
    step();
    chk("ini_voltar", 32'(db_estado), 0);
    step();
    chk("ini_voltar2", 32'(db_estado), 0);
    chk("ini_voltar_zera", 32'(zera), 0);
    iniciar = 1'b0;
    voltar  = 1'b0;

    // all hits
    iniciar_jogo();
    hits = 0;
    base = n_acerto;
    for (int r = 0; r < ROUNDS; r++)
      rodada(r, $urandom_range(0, T_PLAY - 1), 1'b1, 1'b0);
    fim_jogo(hits, base);
    chk("all_hits", 32'(hits), 32'(ROUNDS));

    // held button, re-press, miss, tie
    iniciar_jogo();
    hits = 0;
    base = n_acerto;
    rodada(0, 0, 1'b1, 1'b1);
    rodada(1, 2, 1'b1, 1'b0);
    rodada(2, $urandom_range(0, T_PLAY - 1), 1'b0, 1'b0);
    rodada(3, T_PLAY - 1, 1'b1, 1'b0);
    fim_jogo(hits, base);

    for (int g = 0; g < 3; g++) begin
      iniciar_jogo();
      hits = 0;
      base = n_acerto;
      for (int r = 0; r < ROUNDS; r++)
        rodada(r, $urandom_range(0, T_PLAY + 1),
               1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0);
      fim_jogo(hits, base);
    end

    // abort from ESPERA with a simultaneous press
    iniciar_jogo();
    rodada(0, 1, 1'b1, 1'b0);
    n = 0;
    while (mostra === 1'b1 && n < T_SHOW + 4) begin
      n++;
      step();
    end
    step();
    step();
    voltar = 1'b1;
    botoes = 4'b1000;
    step();
    chk("abort", 32'(db_estado), 0);
    chk("abort_no_reg", 32'(registra), 0);
    voltar = 1'b0;
    botoes = 4'b0000;
    step();
    chk("abort_idle", 32'(db_estado), 0);
    chk("abort_no_reg2", 32'(registra), 0);

    // asynchronous reset in the middle of MOSTRA
    iniciar_jogo();
    rodada(0, 3, 1'b1, 1'b0);
    step();
    step();
    chk("pre_rst_mostra", 32'(mostra), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_estado", 32'(db_estado), 0);
    chk("rst_mid_outs", 32'({zera, mostra, registra, conta_acerto,
                             timeout, pronto}), 0);
    chk("rst_mid_indice", 32'(indice), 0);
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_idle", 32'(db_estado), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
